range_health_monitor: RTL and testbench

Parametrised multi-channel environmental range monitor for the grow-controller sensor path. Each channel's sample is checked against runtime-programmable min/max thresholds. The in/out-of-range decision is debounced over consecutive samples. The block produces a percentage health score and a latched alarm with acknowledge. It sits between the sensor front-ends (temperature, humidity, light, moisture, …) and the actuator/status logic.

---
 rtl/range_health_monitor.sv | 174 +++++++++++++++++
 tb/tb_range_health_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/range_health_monitor.sv
`default_nettype none
// ============================================================================
// Module      : range_health_monitor
// Description : Multi-channel min/max range monitor. Each channel is compared
//               against its own programmable window and the result is
//               debounced. The block reports a percentage health score and
//               runs a NORMAL/WARN/ALARM state machine; ALARM is cleared by
//               an operator acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module range_health_monitor #(
  parameter int NCH           = 4,
  parameter int W             = 8,
  parameter int DEBOUNCE      = 3,
  parameter int ALARM_SAMPLES = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sample_valid,
  input  logic [NCH*W-1:0]                       sample_data,
  input  logic                                   cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_addr,
  input  logic [W-1:0]                           cfg_min,
  input  logic [W-1:0]                           cfg_max,
  output logic [NCH-1:0]                         chan_ok,
  output logic [7:0]                             health,
  output logic                                   health_valid,
  output logic                                   alarm,
  output logic                                   warn,
  input  logic                                   alarm_ack
);

  localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(DEBOUNCE + 1);
  localparam int FW  = $clog2(ALARM_SAMPLES + 1);
  localparam int PW  = $clog2(NCH + 1);
  // Wide enough for 100*NCH and never narrower than the 8-bit health port.
  localparam int HW  = ($clog2(100 * NCH + 1) > 8) ? $clog2(100 * NCH + 1) : 8;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_ALARM  = 2'd2
  } state_t;

  state_t          state;
  logic [FW-1:0]   fault_cnt;
  logic            sample_d;
  logic [PW-1:0]   pop;
  logic            all_ok;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_chan
      logic [W-1:0]  thr_min;
      logic [W-1:0]  thr_max;
      logic [W-1:0]  x;
      logic          raw;
      logic          ok;
      logic [CW-1:0] cnt;

      assign x   = sample_data[i*W +: W];
      // An inverted window (min > max) can never be satisfied, so raw is 0.
      assign raw = (thr_min <= x) && (x <= thr_max);
      assign chan_ok[i] = ok;

      // Threshold registers; addresses that match no channel are dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          thr_min <= '0;
          thr_max <= '1;
        end else if (cfg_we && (cfg_addr == AW'(i))) begin
          thr_min <= cfg_min;
          thr_max <= cfg_max;
        end
      end

      // Debounce: ok flips only after DEBOUNCE consecutive disagreeing samples.
      always_ff @(posedge clk) begin
        if (rst) begin
          ok  <= 1'b0;
          cnt <= '0;
        end else if (sample_valid) begin
          if (raw == ok) begin
            cnt <= '0;
          end else if (cnt + CW'(1) == CW'(DEBOUNCE)) begin
            ok  <= ~ok;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  endgenerate

  // Count of channels currently in range.
  always_comb begin
    pop = '0;
    for (int k = 0; k < NCH; k++) begin
      pop = pop + PW'(chan_ok[k]);
    end
  end

  assign all_ok = &chan_ok;

  // One-cycle delay of the sample strobe so scoring sees the updated chan_ok.
  always_ff @(posedge clk) begin
    if (rst) sample_d <= 1'b0;
    else     sample_d <= sample_valid;
  end

  // Health score and alarm state machine; ack is honoured on any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_NORMAL;
      fault_cnt    <= '0;
      warn         <= 1'b0;
      alarm        <= 1'b0;
      health       <= '0;
      health_valid <= 1'b0;
    end else begin
      health_valid <= sample_d;
      if (sample_d) begin
        health <= 8'((HW'(pop) * HW'(100)) / HW'(NCH));
      end
      case (state)
        ST_NORMAL: begin
          if (sample_d && !all_ok) begin
            fault_cnt <= FW'(1);
            if (ALARM_SAMPLES == 1) begin
              state <= ST_ALARM;
              alarm <= 1'b1;
            end else begin
              state <= ST_WARN;
              warn  <= 1'b1;
            end
          end
        end
        ST_WARN: begin
          if (sample_d) begin
            if (all_ok) begin
              state     <= ST_NORMAL;
              fault_cnt <= '0;
              warn      <= 1'b0;
            end else if (fault_cnt + FW'(1) == FW'(ALARM_SAMPLES)) begin
              state     <= ST_ALARM;
              fault_cnt <= fault_cnt + FW'(1);
              warn      <= 1'b0;
              alarm     <= 1'b1;
            end else begin
              fault_cnt <= fault_cnt + FW'(1);
            end
          end
        end
        ST_ALARM: begin
          if (alarm_ack && all_ok) begin
            state     <= ST_NORMAL;
            fault_cnt <= '0;
            alarm     <= 1'b0;
          end
        end
        default: begin
          state     <= ST_NORMAL;
          fault_cnt <= '0;
          warn      <= 1'b0;
          alarm     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_range_health_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_health_monitor
// Description : Directed self-checking bench for range_health_monitor with a
//               4-channel and a 3-channel instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_health_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 4-channel instance
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_min, cfg_max;
  logic        alarm_ack;
  logic [3:0]  chan_ok;
  logic [7:0]  health;
  logic        health_valid, alarm, warn;

  // 3-channel instance
  logic        s3_valid;
  logic [23:0] s3_data;
  logic        c3_we;
  logic [1:0]  c3_addr;
  logic [7:0]  c3_min, c3_max;
  logic        ack3;
  logic [2:0]  ok3;
  logic [7:0]  health3;
  logic        hv3, alarm3, warn3;

  int checks   = 0;
  int failures = 0;

  range_health_monitor #(.NCH(4), .W(8), .DEBOUNCE(3), .ALARM_SAMPLES(8)) u4 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .chan_ok(chan_ok), .health(health), .health_valid(health_valid),
    .alarm(alarm), .warn(warn), .alarm_ack(alarm_ack)
  );

  range_health_monitor #(.NCH(3), .W(8), .DEBOUNCE(3), .ALARM_SAMPLES(8)) u3 (
    .clk(clk), .rst(rst), .sample_valid(s3_valid), .sample_data(s3_data),
    .cfg_we(c3_we), .cfg_addr(c3_addr), .cfg_min(c3_min), .cfg_max(c3_max),
    .chan_ok(ok3), .health(health3), .health_valid(hv3),
    .alarm(alarm3), .warn(warn3), .alarm_ack(ack3)
  );

  function automatic logic [31:0] pk4(input logic [7:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One sample, then one more edge so health/warn/alarm reflect it.
  task automatic step(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic step3(input logic [23:0] d);
    s3_valid = 1'b1;
    s3_data  = d;
    tick();
    s3_valid = 1'b0;
    tick();
  endtask

  task automatic cfg4(input logic [1:0] a, input logic [7:0] mn, input logic [7:0] mx);
    cfg_we = 1'b1; cfg_addr = a; cfg_min = mn; cfg_max = mx;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg3(input logic [1:0] a, input logic [7:0] mn, input logic [7:0] mx);
    c3_we = 1'b1; c3_addr = a; c3_min = mn; c3_max = mx;
    tick();
    c3_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (chan_ok !== 4'b0000) begin failures++; $display("FAIL reset_chan_ok got=%b exp=0000", chan_ok); end
    checks++; if (health !== 8'd0) begin failures++; $display("FAIL reset_health got=%0d exp=0", health); end
    checks++; if ({health_valid, warn, alarm} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {health_valid, warn, alarm}); end
  endtask

  // Back-to-back samples: chan_ok rises on the 3rd, health one edge later.
  task automatic test_back_to_back;
    sample_valid = 1'b1;
    sample_data  = pk4(20, 20, 20, 20);
    tick();
    checks++; if (chan_ok !== 4'b0000) begin failures++; $display("FAIL b2b_ok_s1 got=%b exp=0000", chan_ok); end
    checks++; if (health_valid !== 1'b0) begin failures++; $display("FAIL b2b_hv_s1 got=%b exp=0", health_valid); end
    tick();
    checks++; if (chan_ok !== 4'b0000) begin failures++; $display("FAIL b2b_ok_s2 got=%b exp=0000", chan_ok); end
    checks++; if ({health_valid, health} !== {1'b1, 8'd0}) begin failures++; $display("FAIL b2b_health_s2 got=%b/%0d exp=1/0", health_valid, health); end
    tick();
    sample_valid = 1'b0;
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL b2b_ok_s3 got=%b exp=1111", chan_ok); end
    checks++; if (warn !== 1'b1) begin failures++; $display("FAIL b2b_warn_s3 got=%b exp=1", warn); end
    tick();
    checks++; if ({health_valid, health} !== {1'b1, 8'd100}) begin failures++; $display("FAIL b2b_health100 got=%b/%0d exp=1/100", health_valid, health); end
    checks++; if ({warn, alarm} !== 2'b00) begin failures++; $display("FAIL b2b_normal got=%b exp=00", {warn, alarm}); end
    tick();
    checks++; if (health_valid !== 1'b0) begin failures++; $display("FAIL b2b_hv_pulse got=%b exp=0", health_valid); end
  endtask

  task automatic test_debounce;
    cfg4(2'd0, 8'd18, 8'd24);
    for (int k = 0; k < 3; k++) begin
      step(pk4(30, 20, 20, 20));
      step(pk4(20, 20, 20, 20));
    end
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL alt_no_flip got=%b exp=1111", chan_ok); end
    step(pk4(30, 20, 20, 20));
    step(pk4(30, 20, 20, 20));
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL drop_s2 got=%b exp=1111", chan_ok); end
    step(pk4(30, 20, 20, 20));
    checks++; if (chan_ok !== 4'b1110) begin failures++; $display("FAIL drop_s3 got=%b exp=1110", chan_ok); end
    checks++; if (health !== 8'd75) begin failures++; $display("FAIL drop_health got=%0d exp=75", health); end
    checks++; if ({warn, alarm} !== 2'b10) begin failures++; $display("FAIL drop_warn got=%b exp=10", {warn, alarm}); end
  endtask

  // Continues from WARN after fault strobe 1.
  task automatic test_alarm;
    for (int k = 2; k <= 7; k++) begin
      step(pk4(30, 20, 20, 20));
      checks++; if ({warn, alarm} !== 2'b10) begin failures++; $display("FAIL warn_strobe%0d got=%b exp=10", k, {warn, alarm}); end
    end
    step(pk4(30, 20, 20, 20));
    checks++; if ({warn, alarm} !== 2'b01) begin failures++; $display("FAIL alarm_strobe8 got=%b exp=01", {warn, alarm}); end
    for (int k = 0; k < 3; k++) step(pk4(20, 20, 20, 20));
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL alarm_recover_ok got=%b exp=1111", chan_ok); end
    tick();
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_latched got=%b exp=1", alarm); end
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    checks++; if ({warn, alarm} !== 2'b00) begin failures++; $display("FAIL alarm_ack_clear got=%b exp=00", {warn, alarm}); end
  endtask

  task automatic test_ack_ignored;
    cfg4(2'd2, 8'd10, 8'd200);
    for (int k = 0; k < 10; k++) step(pk4(20, 20, 5, 20));
    checks++; if ({warn, alarm} !== 2'b01) begin failures++; $display("FAIL ch2_alarm got=%b exp=01", {warn, alarm}); end
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL ack_while_faulty got=%b exp=1", alarm); end
    for (int k = 0; k < 3; k++) step(pk4(20, 20, 20, 20));
    tick();
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL ch2_recover_ok got=%b exp=1111", chan_ok); end
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL ack_not_remembered got=%b exp=1", alarm); end
    alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL fresh_ack got=%b exp=0", alarm); end
  endtask

  task automatic test_cfg_edge;
    cfg4(2'd1, 8'd50, 8'd40);
    step(pk4(20, 45, 20, 20));
    step(pk4(20, 45, 20, 20));
    checks++; if (chan_ok !== 4'b1111) begin failures++; $display("FAIL inv_s2 got=%b exp=1111", chan_ok); end
    step(pk4(20, 45, 20, 20));
    checks++; if (chan_ok !== 4'b1101) begin failures++; $display("FAIL inv_window got=%b exp=1101", chan_ok); end
    checks++; if (health !== 8'd75) begin failures++; $display("FAIL inv_health got=%0d exp=75", health); end
    // ch0 debounce count at 2, then the deciding sample coincides with a write
    step(pk4(30, 45, 20, 20));
    step(pk4(30, 45, 20, 20));
    checks++; if (chan_ok !== 4'b1101) begin failures++; $display("FAIL same_cycle_pre got=%b exp=1101", chan_ok); end
    sample_valid = 1'b1;
    sample_data  = pk4(30, 45, 20, 20);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_min = 8'd0; cfg_max = 8'd40;
    tick();
    sample_valid = 1'b0;
    cfg_we = 1'b0;
    checks++; if (chan_ok !== 4'b1100) begin failures++; $display("FAIL same_cycle_old_thr got=%b exp=1100", chan_ok); end
    tick();
    for (int k = 0; k < 3; k++) step(pk4(30, 45, 20, 20));
    checks++; if (chan_ok !== 4'b1101) begin failures++; $display("FAIL new_thr_applied got=%b exp=1101", chan_ok); end
  endtask

  task automatic test_nch3;
    cfg3(2'd3, 8'd50, 8'd40);
    for (int k = 0; k < 3; k++) step3({8'd20, 8'd20, 8'd20});
    checks++; if (ok3 !== 3'b111) begin failures++; $display("FAIL n3_bad_addr got=%b exp=111", ok3); end
    checks++; if (health3 !== 8'd100) begin failures++; $display("FAIL n3_health100 got=%0d exp=100", health3); end
    cfg3(2'd2, 8'd100, 8'd200);
    for (int k = 0; k < 3; k++) step3({8'd20, 8'd20, 8'd20});
    checks++; if (ok3 !== 3'b011) begin failures++; $display("FAIL n3_ch2_fault got=%b exp=011", ok3); end
    checks++; if (health3 !== 8'd66) begin failures++; $display("FAIL n3_health66 got=%0d exp=66", health3); end
    checks++; if (warn3 !== 1'b1) begin failures++; $display("FAIL n3_warn got=%b exp=1", warn3); end
    // Reset with a sample in flight and another being presented.
    s3_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s3_valid = 1'b0;
    checks++; if ({ok3, health3, hv3, warn3, alarm3} !== 14'd0) begin failures++; $display("FAIL n3_mid_reset got=%b/%0d/%b%b%b exp=000/0/000", ok3, health3, hv3, warn3, alarm3); end
    checks++; if (chan_ok !== 4'b0000) begin failures++; $display("FAIL n4_mid_reset got=%b exp=0000", chan_ok); end
    tick();
    checks++; if (hv3 !== 1'b0) begin failures++; $display("FAIL n3_inflight_dropped got=%b exp=0", hv3); end
    for (int k = 0; k < 3; k++) step3({8'd20, 8'd20, 8'd20});
    checks++; if (ok3 !== 3'b111) begin failures++; $display("FAIL n3_thr_reset got=%b exp=111", ok3); end
    checks++; if (health3 !== 8'd100) begin failures++; $display("FAIL n3_thr_reset_health got=%0d exp=100", health3); end
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0; sample_data = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_min = '0; cfg_max = '0; alarm_ack = 1'b0;
    s3_valid = 1'b0; s3_data = '0;
    c3_we = 1'b0; c3_addr = '0; c3_min = '0; c3_max = '0; ack3 = 1'b0;
    test_reset();
    test_back_to_back();
    test_debounce();
    test_alarm();
    test_ack_ignored();
    test_cfg_edge();
    test_nch3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
